uart_rx_pkt_ctrl: RTL and testbench

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

---
 rtl/uart_rx_pkt_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// UART packet receiver: hunts for SYNC, collects ADDR/LEN/payload/CHK, verifies the
// running checksum and replays the payload as a burst of register writes.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_frame,
    input  logic       rx_done,
    input  logic       frame_error,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       rx_overrun,
    output logic       busy
);

    localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT_CYC);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        ERR_PARITY   = 2'd0,
        ERR_CHECKSUM = 2'd1,
        ERR_LENGTH   = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_t;

    state_t           state;
    logic [7:0]       base;
    logic [7:0]       len;
    logic [7:0]       idx;
    logic [7:0]       sum;
    logic [CNT_W-1:0] to_cnt;
    logic [7:0]       buffer [2**BUF_AW];

    logic [7:0]        idx_nxt;
    logic [BUF_AW-1:0] wr_ptr;
    logic [BUF_AW-1:0] rd_ptr;

    assign idx_nxt = idx + 8'd1;
    assign wr_ptr  = idx[BUF_AW-1:0];
    assign rd_ptr  = idx_nxt[BUF_AW-1:0];

    // NOTE: the payload buffer has no reset; every entry is written in DATA before
    // WRITE reads it, so clearing it would only add reset fan-out to a RAM-like array.
    always_ff @(posedge clk) begin
        if (state == S_DATA && rx_done && !frame_error)
            buffer[wr_ptr] <= rx_frame;
    end

    // NOTE: the per-cycle pulse defaults and the counter increment at the top are
    // non-blocking, so any later assignment in the same branch overrides them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_HUNT;
            base       <= '0;
            len        <= '0;
            idx        <= '0;
            sum        <= '0;
            to_cnt     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            pkt_ok     <= 1'b0;
            pkt_err    <= 1'b0;
            err_code   <= '0;
            rx_overrun <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pkt_ok     <= 1'b0;
            pkt_err    <= 1'b0;
            rx_overrun <= 1'b0;

            case (state)
                S_HUNT: begin
                    to_cnt <= '0;
                    if (rx_done && !frame_error && rx_frame == SYNC_BYTE) begin
                        state <= S_ADDR;
                        busy  <= 1'b1;
                    end
                end

                S_ADDR, S_LEN, S_DATA, S_CHK: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (rx_done) begin
                        // A received byte always wins over a coincident timeout.
                        to_cnt <= '0;
                        if (frame_error) begin
                            state    <= S_HUNT;
                            busy     <= 1'b0;
                            pkt_err  <= 1'b1;
                            err_code <= ERR_PARITY;
                        end else if (state == S_ADDR) begin
                            base  <= rx_frame;
                            sum   <= rx_frame;
                            state <= S_LEN;
                        end else if (state == S_LEN) begin
                            if (rx_frame == 8'd0 || rx_frame > MAX_LEN_B) begin
                                state    <= S_HUNT;
                                busy     <= 1'b0;
                                pkt_err  <= 1'b1;
                                err_code <= ERR_LENGTH;
                            end else begin
                                len   <= rx_frame;
                                idx   <= '0;
                                sum   <= sum + rx_frame;
                                state <= S_DATA;
                            end
                        end else if (state == S_DATA) begin
                            sum <= sum + rx_frame;
                            idx <= idx_nxt;
                            if (idx == len - 8'd1)
                                state <= S_CHK;
                        end else begin
                            if (rx_frame == sum) begin
                                state   <= S_WRITE;
                                idx     <= '0;
                                wr_en   <= 1'b1;
                                wr_addr <= base;
                                wr_data <= buffer['0];
                            end else begin
                                state    <= S_HUNT;
                                busy     <= 1'b0;
                                pkt_err  <= 1'b1;
                                err_code <= ERR_CHECKSUM;
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt   <= '0;
                        state    <= S_HUNT;
                        busy     <= 1'b0;
                        pkt_err  <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end

                S_WRITE: begin
                    to_cnt <= '0;
                    if (rx_done)
                        rx_overrun <= 1'b1;
                    if (wr_en && wr_ready) begin
                        if (idx == len - 8'd1) begin
                            wr_en  <= 1'b0;
                            pkt_ok <= 1'b1;
                            state  <= S_HUNT;
                            busy   <= 1'b0;
                        end else begin
                            idx     <= idx_nxt;
                            wr_addr <= base + idx_nxt;
                            wr_data <= buffer[rd_ptr];
                        end
                    end
                end

                default: begin
                    state <= S_HUNT;
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: expected writes and packet events are queued
// as bytes are driven and compared by a negedge monitor as the DUT produces them.
module tb_uart_rx_pkt_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         TIMEOUT = 20;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [3:0] EV_OK   = 4'b1000;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_frame;
    logic       rx_done;
    logic       frame_error;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       rx_overrun;
    logic       busy;

    wr_t        exp_wr[$];
    logic [3:0] exp_evt[$];
    logic [7:0] tx_q[$];
    int         hs_cyc[$];
    logic [3:0] obs_ev;

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int last_rx_cyc = 0;
    int err_cyc     = 0;
    int stall_cnt   = 0;
    int obs_ovr     = 0;
    int exp_ovr     = 0;

    uart_rx_pkt_ctrl #(
        .SYNC_BYTE  (SYNC),
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_frame   (rx_frame),
        .rx_done    (rx_done),
        .frame_error(frame_error),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .err_code   (err_code),
        .rx_overrun (rx_overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ev_err(input logic [1:0] code);
        return {2'b01, code};
    endfunction

    // Scoreboard side: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 32'(wr_en), 32'd0);
                end else begin
                    check("wr_addr", 32'(wr_addr), 32'(exp_wr[0].addr));
                    check("wr_data", 32'(wr_data), 32'(exp_wr[0].data));
                    if (wr_ready) begin
                        void'(exp_wr.pop_front());
                        hs_cyc.push_back(cyc);
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            if (pkt_ok || pkt_err) begin
                obs_ev = {pkt_ok, pkt_err, pkt_err ? err_code : 2'b00};
                if (exp_evt.size() == 0)
                    check("evt_unexpected", 32'(obs_ev), 32'd0);
                else
                    check("pkt_event", 32'(obs_ev), 32'(exp_evt.pop_front()));
                if (pkt_err)
                    err_cyc = cyc;
            end
            if (rx_overrun)
                obs_ovr++;
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe = 1'b0);
        rx_frame    = b;
        rx_done     = 1'b1;
        frame_error = fe;
        @(posedge clk);
        #1;
        last_rx_cyc = cyc;
        rx_done     = 1'b0;
        frame_error = 1'b0;
    endtask

    task automatic send_q();
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front());
            idle(2);
        end
    endtask

    task automatic send_valid(input logic [7:0] base, input int n, input logic [7:0] seed);
        logic [7:0] s;
        logic [7:0] p;
        s = base + 8'(n);
        tx_q.push_back(SYNC);
        tx_q.push_back(base);
        tx_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            p = seed + 8'(i * 13);
            s = s + p;
            tx_q.push_back(p);
            exp_wr.push_back(wr_t'{addr: base + 8'(i), data: p});
        end
        tx_q.push_back(s);
        exp_evt.push_back(EV_OK);
        send_q();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        idle(2);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_wr_q"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_evt_q"}, 32'(exp_evt.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end of the test sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        rx_frame    = '0;
        rx_done     = 1'b0;
        frame_error = 1'b0;
        wr_ready    = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({wr_en, wr_addr, wr_data, pkt_ok, pkt_err, err_code, rx_overrun, busy}), 32'd0);
        rst_n = 1'b1;
        idle(2);
        check("idle_after_reset", 32'({busy, wr_en}), 32'd0);

        // Non-SYNC bytes and a SYNC with a parity error are ignored in HUNT
        send_byte(8'h3C);
        send_byte(SYNC, 1'b1);
        idle(2);
        check("hunt_ignores", 32'(busy), 32'd0);

        // Basic packet: two back-to-back writes and one pkt_ok
        hs_cyc.delete();
        exp_wr.push_back(wr_t'{addr: 8'h10, data: 8'h11});
        exp_wr.push_back(wr_t'{addr: 8'h11, data: 8'h22});
        exp_evt.push_back(EV_OK);
        send_byte(SYNC);
        check("busy_after_sync", 32'(busy), 32'd1);
        idle(2);
        tx_q = {8'h10, 8'h02, 8'h11, 8'h22};
        send_q();
        send_byte(8'h45);
        check("wr_en_after_chk", 32'(wr_en), 32'd1);
        wait_idle("pkt1_idle");
        check("pkt1_handshakes", 32'(hs_cyc.size()), 32'd2);
        if (hs_cyc.size() == 2)
            check("pkt1_back_to_back", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
        check_drained("pkt1");

        // Bad checksum, then a good packet is still accepted
        exp_evt.push_back(ev_err(2'd1));
        tx_q = {SYNC, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46};
        send_q();
        wait_idle("badchk_idle");
        check("badchk_err_code", 32'(err_code), 32'd1);
        send_valid(8'h20, 1, 8'h33);
        wait_idle("after_badchk_idle");
        check_drained("badchk");

        // Length errors: LEN=0 and LEN=MAX_LEN+1; bytes after LEN are hunted
        exp_evt.push_back(ev_err(2'd2));
        tx_q = {SYNC, 8'h30, 8'h00};
        send_q();
        check("len0_err_code", 32'(err_code), 32'd2);
        send_valid(8'h30, 1, 8'h44);
        wait_idle("len0_follow_idle");
        exp_evt.push_back(ev_err(2'd2));
        tx_q = {SYNC, 8'h30, 8'(MAX_LEN + 1), 8'h7F, 8'h00};
        send_q();
        check("lenmax_hunting", 32'(busy), 32'd0);
        check("lenmax_err_code", 32'(err_code), 32'd2);
        send_valid(8'h40, MAX_LEN, 8'h01);
        wait_idle("lenmax_full_idle");
        check_drained("len");

        // Inter-byte timeout
        exp_evt.push_back(ev_err(2'd3));
        tx_q = {SYNC, 8'hFF, 8'h02, 8'h11};
        send_q();
        wait_idle("timeout_idle");
        check("timeout_err_code", 32'(err_code), 32'd3);
        check("timeout_latency", 32'(err_cyc - last_rx_cyc), 32'(TIMEOUT));
        check_drained("timeout");

        // Stalled first write, overrun during WRITE, address wrap FF->00
        stall_cnt = 0;
        obs_ovr   = 0;
        exp_ovr   = 1;
        exp_wr.push_back(wr_t'{addr: 8'hFF, data: 8'h01});
        exp_wr.push_back(wr_t'{addr: 8'h00, data: 8'h02});
        exp_wr.push_back(wr_t'{addr: 8'h01, data: 8'h03});
        exp_evt.push_back(EV_OK);
        tx_q = {SYNC, 8'hFF, 8'h03, 8'h01, 8'h02, 8'h03};
        send_q();
        wr_ready = 1'b0;
        send_byte(8'h08);
        check("stall_wr_en", 32'(wr_en), 32'd1);
        send_byte(8'h5A);
        idle(4);
        wr_ready = 1'b1;
        wait_idle("stall_idle");
        check("stall_cycles", 32'(stall_cnt), 32'd5);
        check("overrun_count", 32'(obs_ovr), 32'(exp_ovr));
        check_drained("stall");

        // Parity error on a DATA byte
        exp_evt.push_back(ev_err(2'd0));
        tx_q = {SYNC, 8'h50, 8'h02};
        send_q();
        send_byte(8'h11, 1'b1);
        wait_idle("parity_idle");
        check("parity_err_code", 32'(err_code), 32'd0);
        check_drained("parity");

        // Reset in the middle of a stalled WRITE
        wr_ready = 1'b0;
        exp_wr.push_back(wr_t'{addr: 8'h60, data: 8'h01});
        tx_q = {SYNC, 8'h60, 8'h03, 8'h01, 8'h02, 8'h03};
        send_q();
        send_byte(8'h69);
        idle(2);
        check("midwrite_wr_en", 32'(wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midwrite_reset_outputs",
              32'({wr_en, wr_addr, wr_data, pkt_ok, pkt_err, err_code, rx_overrun, busy}), 32'd0);
        exp_wr.delete();
        idle(2);
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        idle(TIMEOUT + 10);
        check("post_reset_quiet", 32'({wr_en, busy, err_code}), 32'd0);
        check("post_reset_overrun", 32'(obs_ovr), 32'(exp_ovr));
        check_drained("reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
